mem_arbiter: RTL and testbench

Two-requester arbiter sharing the single SOC RAM port (1-cycle read latency, byte write mask) between the CPU (requester 0) and a second bus master such as a DMA or boot loader (requester 1). Arbitration is round-robin with a bounded-burst rule, and the grant is issued in the same cycle as the request. Read data is returned to the owning requester one cycle after its grant. The block sits between both masters and the `Memory` instance, with IO decode remaining outside it.

---
 rtl/mem_arbiter_pkg.sv | 7 +
 rtl/mem_arbiter.sv | 100 ++++++++++
 tb/tb_mem_arbiter.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the two-requester SOC RAM arbiter.
// Requester indices match the m0_*/m1_* port prefixes.
package mem_arbiter_pkg;
    localparam int REQ_CPU       = 0;
    localparam int REQ_AUX       = 1;
    localparam int BURST_DEFAULT = 4;
endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter with bounded bursts between the CPU and a second master
// sharing one RAM port; zero-cycle grant, one-cycle read return.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int BURST = BURST_DEFAULT
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wmask,
    input  logic        m0_rstrb,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wmask,
    input  logic        m1_rstrb,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    output logic [3:0]  ram_wmask,
    output logic        ram_rstrb,
    input  logic [31:0] ram_rdata
);
    localparam int            CW      = $clog2(BURST + 1);
    localparam logic [CW-1:0] BURST_C = CW'(BURST);

    logic          req0;
    logic          req1;
    logic          both;
    logic          any_gnt;
    logic          win;
    logic          pure_rd;
    logic [3:0]    sel_wmask;
    logic          sel_rstrb;

    logic          owner;
    logic [CW-1:0] cnt;
    logic          rd_pend;
    logic          rd_who;

    always_comb begin
        req0    = m0_rstrb | (|m0_wmask);
        req1    = m1_rstrb | (|m1_wmask);
        both    = req0 & req1;
        any_gnt = (req0 | req1) & resetn;
        // Under contention the owner keeps the port until its burst budget is spent.
        if (both) begin
            win = (cnt < BURST_C) ? owner : ~owner;
        end else begin
            win = req1 & ~req0;
        end
        sel_wmask = win ? m1_wmask : m0_wmask;
        sel_rstrb = win ? m1_rstrb : m0_rstrb;
        pure_rd   = sel_rstrb & ~(|sel_wmask);
    end

    assign m0_gnt    = any_gnt & (win == 1'(REQ_CPU));
    assign m1_gnt    = any_gnt & (win == 1'(REQ_AUX));

    assign ram_addr  = win ? m1_addr  : m0_addr;
    assign ram_wdata = win ? m1_wdata : m0_wdata;
    assign ram_wmask = any_gnt ? sel_wmask : 4'b0000;
    assign ram_rstrb = any_gnt & pure_rd;

    // Gating with resetn drops a read whose data would land during reset.
    assign m0_rvalid = resetn & rd_pend & (rd_who == 1'(REQ_CPU));
    assign m1_rvalid = resetn & rd_pend & (rd_who == 1'(REQ_AUX));
    assign m0_rdata  = ram_rdata;
    assign m1_rdata  = ram_rdata;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            owner   <= 1'b0;
            cnt     <= '0;
            rd_pend <= 1'b0;
            rd_who  <= 1'b0;
        end else begin
            rd_pend <= any_gnt & pure_rd;
            if (any_gnt) begin
                rd_who <= win;
                if (win == owner) begin
                    if (!both) begin
                        cnt <= '0;
                    end else if (cnt != BURST_C) begin
                        cnt <= cnt + CW'(1);
                    end
                end else begin
                    owner <= win;
                    cnt   <= CW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a BURST=4 instance against a small RAM model
// driven from a vector table, and a BURST=1 instance for alternation.
module tb_mem_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // BURST=4 instance signals
    logic        resetn;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_wmask, m1_wmask;
    logic        m0_rstrb, m1_rstrb;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;
    logic [3:0]  ram_wmask;
    logic        ram_rstrb;

    // BURST=1 instance signals
    logic        b_resetn;
    logic [31:0] b0_addr, b0_wdata, b1_addr, b1_wdata;
    logic [3:0]  b0_wmask, b1_wmask;
    logic        b0_rstrb, b1_rstrb;
    logic        b0_gnt, b1_gnt, b0_rvalid, b1_rvalid;
    logic [31:0] b0_rdata, b1_rdata;
    logic [31:0] b_ram_addr, b_ram_wdata;
    logic [31:0] b_ram_rdata = 32'h0;
    logic [3:0]  b_ram_wmask;
    logic        b_ram_rstrb;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.BURST(4)) dut (
        .clk(clk), .resetn(resetn),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wmask(m0_wmask), .m0_rstrb(m0_rstrb),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask), .m1_rstrb(m1_rstrb),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wmask(ram_wmask),
        .ram_rstrb(ram_rstrb), .ram_rdata(ram_rdata)
    );

    mem_arbiter #(.BURST(1)) dut1 (
        .clk(clk), .resetn(b_resetn),
        .m0_addr(b0_addr), .m0_wdata(b0_wdata), .m0_wmask(b0_wmask), .m0_rstrb(b0_rstrb),
        .m0_gnt(b0_gnt), .m0_rvalid(b0_rvalid), .m0_rdata(b0_rdata),
        .m1_addr(b1_addr), .m1_wdata(b1_wdata), .m1_wmask(b1_wmask), .m1_rstrb(b1_rstrb),
        .m1_gnt(b1_gnt), .m1_rvalid(b1_rvalid), .m1_rdata(b1_rdata),
        .ram_addr(b_ram_addr), .ram_wdata(b_ram_wdata), .ram_wmask(b_ram_wmask),
        .ram_rstrb(b_ram_rstrb), .ram_rdata(b_ram_rdata)
    );

    // RAM model: byte-masked write and registered read on the same edge
    logic [31:0] mem [0:63];
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (ram_wmask[b]) mem[ram_addr[7:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
        end
        if (ram_rstrb) ram_rdata <= mem[ram_addr[7:2]];
    end

    typedef struct {
        logic        rn;
        logic        r0;
        logic [3:0]  wm0;
        logic [31:0] a0;
        logic [31:0] wd0;
        logic        r1;
        logic [3:0]  wm1;
        logic [31:0] a1;
        logic [31:0] wd1;
        logic        g0;
        logic        g1;
        logic        rs;
        logic [3:0]  wm;
        logic        rv0;
        logic        rv1;
        logic [31:0] rd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rn, logic r0, logic [3:0] wm0, logic [31:0] a0,
                                logic [31:0] wd0, logic r1, logic [3:0] wm1, logic [31:0] a1,
                                logic [31:0] wd1, logic g0, logic g1, logic rs, logic [3:0] wm,
                                logic rv0, logic rv1, logic [31:0] rd);
        vec_t v;
        v.rn = rn; v.r0 = r0; v.wm0 = wm0; v.a0 = a0; v.wd0 = wd0;
        v.r1 = r1; v.wm1 = wm1; v.a1 = a1; v.wd1 = wd1;
        v.g0 = g0; v.g1 = g1; v.rs = rs; v.wm = wm; v.rv0 = rv0; v.rv1 = rv1; v.rd = rd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        string t;
        @(posedge clk);
        #1;
        resetn = v.rn;
        m0_rstrb = v.r0; m0_wmask = v.wm0; m0_addr = v.a0; m0_wdata = v.wd0;
        m1_rstrb = v.r1; m1_wmask = v.wm1; m1_addr = v.a1; m1_wdata = v.wd1;
        #3;
        t = $sformatf("vec%0d", idx);
        chk({t, ".m0_gnt"}, 32'(m0_gnt), 32'(v.g0));
        chk({t, ".m1_gnt"}, 32'(m1_gnt), 32'(v.g1));
        chk({t, ".ram_rstrb"}, 32'(ram_rstrb), 32'(v.rs));
        chk({t, ".ram_wmask"}, 32'(ram_wmask), 32'(v.wm));
        chk({t, ".m0_rvalid"}, 32'(m0_rvalid), 32'(v.rv0));
        chk({t, ".m1_rvalid"}, 32'(m1_rvalid), 32'(v.rv1));
        if (v.rv0) chk({t, ".m0_rdata"}, m0_rdata, v.rd);
        if (v.rv1) chk({t, ".m1_rdata"}, m1_rdata, v.rd);
        if (v.g0 || v.g1) chk({t, ".ram_addr"}, ram_addr, v.g1 ? v.a1 : v.a0);
        $display("vec%0d rn=%b req=%b%b gnt=%b%b rstrb=%b wmask=%b rvalid=%b%b",
                 idx, v.rn, v.r0 | (|v.wm0), v.r1 | (|v.wm1), m0_gnt, m1_gnt,
                 ram_rstrb, ram_wmask, m0_rvalid, m1_rvalid);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[4]    = 32'hDEADBEEF;   // 0x10
        mem[8]    = 32'h11223344;   // 0x20
        ram_rdata = 32'h0;
        resetn = 1'b0;
        m0_rstrb = 0; m0_wmask = 0; m0_addr = 0; m0_wdata = 0;
        m1_rstrb = 0; m1_wmask = 0; m1_addr = 0; m1_wdata = 0;
        b_resetn = 1'b0;
        b0_rstrb = 0; b0_wmask = 0; b0_addr = 32'h40; b0_wdata = 0;
        b1_rstrb = 0; b1_wmask = 0; b1_addr = 32'h44; b1_wdata = 0;

        //                 rn r0 wm0  a0      wd0           r1 wm1  a1      wd1           g0 g1 rs wm   rv0 rv1 rd
        vecs.push_back(mk(0, 1, 4'h0, 32'h10, 32'h0,        1, 4'h0, 32'h30, 32'h0,        0, 0, 0, 4'h0, 0, 0, 32'h0));
        vecs.push_back(mk(1, 1, 4'h0, 32'h10, 32'h0,        0, 4'h0, 32'h0,  32'h0,        1, 0, 1, 4'h0, 0, 0, 32'h0));
        vecs.push_back(mk(1, 0, 4'h0, 32'h0,  32'h0,        0, 4'h0, 32'h0,  32'h0,        0, 0, 0, 4'h0, 1, 0, 32'hDEADBEEF));
        vecs.push_back(mk(1, 0, 4'h0, 32'h0,  32'h0,        0, 4'h4, 32'h20, 32'h00AB0000, 0, 1, 0, 4'h4, 0, 0, 32'h0));
        vecs.push_back(mk(1, 1, 4'h0, 32'h20, 32'h0,        0, 4'h0, 32'h0,  32'h0,        1, 0, 1, 4'h0, 0, 0, 32'h0));
        vecs.push_back(mk(1, 0, 4'h0, 32'h0,  32'h0,        0, 4'h0, 32'h0,  32'h0,        0, 0, 0, 4'h0, 1, 0, 32'h11AB3344));
        vecs.push_back(mk(1, 1, 4'hF, 32'h30, 32'hCAFEF00D, 0, 4'h0, 32'h0,  32'h0,        1, 0, 0, 4'hF, 0, 0, 32'h0));
        vecs.push_back(mk(1, 0, 4'h0, 32'h0,  32'h0,        0, 4'h0, 32'h0,  32'h0,        0, 0, 0, 4'h0, 0, 0, 32'h0));
        vecs.push_back(mk(1, 0, 4'h0, 32'h0,  32'h0,        1, 4'h0, 32'h30, 32'h0,        0, 1, 1, 4'h0, 0, 0, 32'h0));
        vecs.push_back(mk(1, 0, 4'h0, 32'h0,  32'h0,        0, 4'h0, 32'h0,  32'h0,        0, 0, 0, 4'h0, 0, 1, 32'hCAFEF00D));
        vecs.push_back(mk(0, 0, 4'h0, 32'h0,  32'h0,        0, 4'h0, 32'h0,  32'h0,        0, 0, 0, 4'h0, 0, 0, 32'h0));
        // Continuous contention from reset: m0 x4, m1 x4, m0 x4
        for (int i = 0; i < 12; i++) begin
            vecs.push_back(mk(1, 1, 4'h0, 32'h10, 32'h0, 1, 4'h0, 32'h30, 32'h0,
                              (i < 4 || i >= 8), !(i < 4 || i >= 8), 1, 4'h0,
                              (i > 0) && (i - 1 < 4 || i - 1 >= 8),
                              (i > 0) && (i - 1 >= 4 && i - 1 < 8),
                              (i >= 5 && i <= 8) ? 32'hCAFEF00D : 32'hDEADBEEF));
        end
        vecs.push_back(mk(1, 0, 4'h0, 32'h0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 0, 4'h0, 1, 0, 32'hDEADBEEF));

        foreach (vecs[i]) apply(vecs[i], i);

        // Reset arriving the cycle after an m1 read grant
        @(posedge clk); #1;
        resetn = 1'b1; m0_rstrb = 0; m1_rstrb = 1; m1_addr = 32'h30;
        #3;
        chk("rst_mid.m1_gnt", 32'(m1_gnt), 32'h1);
        $display("rst_mid grant m1_gnt=%b", m1_gnt);
        @(posedge clk); #1;
        resetn = 1'b0; m1_rstrb = 0; m0_rstrb = 1; m0_addr = 32'h10;
        #3;
        chk("rst_mid.owner_before", 32'(dut.owner), 32'h1);
        chk("rst_mid.cnt_before", 32'(dut.cnt), 32'h1);
        chk("rst_mid.m1_rvalid", 32'(m1_rvalid), 32'h0);
        chk("rst_mid.m0_gnt", 32'(m0_gnt), 32'h0);
        chk("rst_mid.ram_rstrb", 32'(ram_rstrb), 32'h0);
        $display("rst_mid in_reset m1_rvalid=%b m0_gnt=%b", m1_rvalid, m0_gnt);
        @(posedge clk); #1;
        resetn = 1'b1; m0_rstrb = 0;
        #3;
        chk("rst_mid.owner_after", 32'(dut.owner), 32'h0);
        chk("rst_mid.cnt_after", 32'(dut.cnt), 32'h0);
        chk("rst_mid.m1_rvalid_after", 32'(m1_rvalid), 32'h0);
        chk("rst_mid.m0_rvalid_after", 32'(m0_rvalid), 32'h0);
        $display("rst_mid after owner=%0d cnt=%0d rvalid=%b%b", dut.owner, dut.cnt, m0_rvalid, m1_rvalid);

        // BURST=1: m1 idle keeps cnt at 0, then strict alternation
        @(posedge clk); #1;
        b_resetn = 1'b1; b0_rstrb = 1;
        #3;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                @(posedge clk); #4;
            end
            chk($sformatf("b1_idle%0d.m0_gnt", i), 32'(b0_gnt), 32'h1);
            chk($sformatf("b1_idle%0d.m1_gnt", i), 32'(b1_gnt), 32'h0);
            chk($sformatf("b1_idle%0d.cnt", i), 32'(dut1.cnt), 32'h0);
            $display("b1_idle%0d gnt=%b%b cnt=%0d", i, b0_gnt, b1_gnt, dut1.cnt);
        end
        @(posedge clk); #1;
        b1_rstrb = 1;
        #3;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                @(posedge clk); #4;
            end
            chk($sformatf("b1_alt%0d.m0_gnt", i), 32'(b0_gnt), 32'((i % 2) == 0));
            chk($sformatf("b1_alt%0d.m1_gnt", i), 32'(b1_gnt), 32'((i % 2) == 1));
            $display("b1_alt%0d gnt=%b%b", i, b0_gnt, b1_gnt);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
